rx_frame_loader: RTL and testbench

- Packet parser between the UART RX byte stream from the PC and the frame transmit RAM.
- Hunts for a 2-byte sync header and writes TOTAL_PIXELS payload bytes to sequential RAM addresses.
- Verifies an 8-bit additive checksum and pulses frame_tick only for a valid frame, which arms the downstream RAM readout.

---
 rtl/rx_frame_loader_if.sv | 22 ++
 rtl/rx_frame_loader.sv | 157 +++++++++++++++
 tb/tb_rx_frame_loader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_loader_if.sv
// RX byte stream in, frame RAM write port out.
// Master drives bytes and observes writes; slave is the loader.
interface rx_frame_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  we;
  logic [DATA_WIDTH-1:0] wData;
  logic [ADDR_WIDTH-1:0] wAddr;

  modport master (
    output rx_data, rx_valid,
    input  we, wData, wAddr
  );

  modport slave (
    input  rx_data, rx_valid,
    output we, wData, wAddr
  );
endinterface

// File: rtl/rx_frame_loader.sv
// Sync-hunting UART packet parser feeding the frame RAM.
// Checks an additive checksum and flags good frames.
module rx_frame_loader #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          TOTAL_PIXELS   = 9600,
  parameter int          ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  rx_frame_loader_if.slave   bus,
  output logic               frame_tick,
  output logic               crc_err,
  output logic               timeout_err,
  output logic               busy,
  output logic [15:0]        frame_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(TOTAL_PIXELS - 1);
  // Compare one short so the pulse lands as the count reaches the limit
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    HUNT0,
    HUNT1,
    PAYLOAD,
    CHECK
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  tick_q, tick_d;
  logic                  crc_q, crc_d;
  logic                  terr_q, terr_d;
  logic                  expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      tick_q  <= 1'b0;
      crc_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      tick_q  <= tick_d;
      crc_q   <= crc_d;
      terr_q  <= terr_d;
    end
  end

  assign expire = (state_q != HUNT0)
                && !bus.rx_valid
                && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    if (bus.rx_valid) begin
      unique case (state_q)
        HUNT0: begin
          if (bus.rx_data == SYNC0)
            state_d = HUNT1;
        end
        HUNT1: begin
          if (bus.rx_data == SYNC1)
            state_d = PAYLOAD;
          else if (bus.rx_data != SYNC0)
            state_d = HUNT0;
        end
        PAYLOAD: begin
          if (idx_q == LAST)
            state_d = CHECK;
        end
        CHECK: state_d = HUNT0;
        default: state_d = HUNT0;
      endcase
    end else if (expire) begin
      state_d = HUNT0;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    sum_d   = sum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    tick_d  = 1'b0;
    crc_d   = 1'b0;
    terr_d  = expire;
    tmo_d   = tmo_q + 1'b1;
    if (state_q == HUNT0 || bus.rx_valid || expire)
      tmo_d = '0;
    if (bus.rx_valid) begin
      unique case (state_q)
        HUNT1: begin
          if (bus.rx_data == SYNC1) begin
            idx_d = '0;
            sum_d = '0;
          end
        end
        PAYLOAD: begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = bus.rx_data;
          sum_d   = sum_q + bus.rx_data;
          if (idx_q != LAST)
            idx_d = idx_q + 1'b1;
        end
        CHECK: begin
          if (bus.rx_data == sum_q) begin
            tick_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
          end else begin
            crc_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.we      = we_q;
  assign bus.wData   = wdata_q;
  assign bus.wAddr   = waddr_q;
  assign frame_tick  = tick_q;
  assign crc_err     = crc_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != HUNT0);
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_rx_frame_loader.sv
// Scoreboard bench for rx_frame_loader.
// Stimulus queues expected writes/pulses; a monitor checks them.
module tb_rx_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick, crc_err, timeout_err, busy;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;

  logic [11:0] wq[$];
  int          eq[$];
  logic [11:0] w;
  int          ev;
  int          ev_exp;

  always #5 clk = ~clk;

  rx_frame_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  rx_frame_loader #(
    .TOTAL_PIXELS  (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .frame_tick (frame_tick),
    .crc_err    (crc_err),
    .timeout_err(timeout_err),
    .busy       (busy),
    .frame_count(frame_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_we", 1, 0);
      end else begin
        w = wq.pop_front();
        chk("waddr", {28'd0, bus.wAddr}, {28'd0, w[11:8]});
        chk("wdata", {24'd0, bus.wData}, {24'd0, w[7:0]});
      end
    end
    ev = frame_tick  ? 1 :
         crc_err     ? 2 :
         timeout_err ? 3 : 0;
    if (ev != 0) begin
      ev_exp = (eq.size() == 0) ? 0 : eq.pop_front();
      chk("event", ev, ev_exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic put(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode,
                            input logic [7:0] ck,
                            input bit good,
                            input int gap);
    logic [7:0] b;
    put(8'hAA); idle(gap);
    put(8'h55); idle(gap);
    for (int i = 0; i < 16; i++) begin
      b = (mode != 0) ? 8'(i * 17) : 8'(i);
      wq.push_back({4'(i), b});
      put(b);
      chk("we_latency", {31'd0, bus.we}, 1);
      idle(gap);
    end
    eq.push_back(good ? 1 : 2);
    put(ck);
    chk("tick_time", {31'd0, frame_tick}, {31'd0, good});
    chk("crc_time", {31'd0, crc_err}, {31'd0, !good});
    chk("busy_after", {31'd0, busy}, 0);
    idle(gap);
  endtask

  task automatic drained(input string nm);
    idle(3);
    chk({nm, "_wq"}, wq.size(), 0);
    chk({nm, "_eq"}, eq.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(3);
    chk("rst_we", {31'd0, bus.we}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cnt", {16'd0, frame_count}, 0);
    chk("rst_addr", {28'd0, bus.wAddr}, 0);
    reset = 1'b0;
    idle(2);

    send_frame(0, 8'h78, 1, 3);
    chk("cnt_good1", {16'd0, frame_count}, 1);
    drained("good1");

    send_frame(0, 8'h79, 0, 3);
    chk("cnt_bad", {16'd0, frame_count}, 1);
    drained("bad");

    put(8'h12); put(8'hAA);
    send_frame(0, 8'h78, 1, 1);
    chk("cnt_hunt", {16'd0, frame_count}, 2);
    put(8'hAA); put(8'h12);
    chk("busy_resync", {31'd0, busy}, 0);
    put(8'h55); put(8'h00); put(8'h01); put(8'h02);
    chk("busy_nosync", {31'd0, busy}, 0);
    drained("hunt");

    put(8'hAA); put(8'h55);
    for (int i = 0; i < 5; i++) begin
      wq.push_back({4'(i), 8'(i + 3)});
      put(8'(i + 3));
    end
    eq.push_back(3);
    k = 0;
    while (k < 150 && timeout_err !== 1'b1) begin
      step();
      k++;
    end
    chk("tmo_cycle", k, 99);
    chk("tmo_busy", {31'd0, busy}, 0);
    send_frame(1, 8'hF8, 1, 2);
    chk("cnt_tmo", {16'd0, frame_count}, 3);
    drained("tmo");

    send_frame(0, 8'h78, 1, 0);
    send_frame(1, 8'hF8, 1, 0);
    chk("cnt_stream", {16'd0, frame_count}, 5);
    drained("stream");

    put(8'hAA); put(8'h55);
    for (int i = 0; i < 8; i++) begin
      wq.push_back({4'(i), 8'(i * 17)});
      put(8'(i * 17));
    end
    reset = 1'b1;
    step();
    chk("mrst_we", {31'd0, bus.we}, 0);
    chk("mrst_data", {24'd0, bus.wData}, 0);
    chk("mrst_addr", {28'd0, bus.wAddr}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_cnt", {16'd0, frame_count}, 0);
    chk("mrst_pulse",
        {29'd0, frame_tick, crc_err, timeout_err}, 0);
    reset = 1'b0;
    step();
    send_frame(0, 8'h78, 1, 1);
    chk("cnt_after_rst", {16'd0, frame_count}, 1);
    drained("mrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
